// File: rtl/spi_sts_event_arb.sv
// Rising-edge event scheduler: latches flag rises as pending/sticky, round-robin serializes them.
// Latency: rise sampled at E0 -> pending after E0 -> evt_valid after E1; one event per 2 cycles max.
// Backpressure: evt_valid/evt_data held until evt_ready; rises on a still-pending bit count as lost.
module spi_sts_event_arb #(
    parameter int N_GROUPS = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  enable,
    input  logic [8*N_GROUPS-1:0] flags_in,
    input  logic                  sticky_clear,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [15:0]           evt_data,
    output logic [8*N_GROUPS-1:0] sticky,
    output logic [15:0]           lost_count,
    output logic                  pending_any
);
    localparam int N  = 8 * N_GROUPS;
    localparam int PW = $clog2(N);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  prev, pending, rise, ack_mask, lost_bits;
    logic [PW-1:0] ptr, idx, sel_idx, sel_hi, sel_lo;
    logic          hi_found, ack, load;
    logic [16:0]   lost_sum;
    logic [15:0]   lost_nxt;

    assign rise        = flags_in & ~prev & {N{enable}};
    assign ack         = (state == PRESENT) && evt_ready;
    assign evt_valid   = (state == PRESENT);
    assign evt_data    = {{(16-PW){1'b0}}, idx};
    assign pending_any = |pending;
    assign lost_bits   = rise & pending & ~ack_mask;

    always_comb begin
        ack_mask      = '0;
        ack_mask[idx] = ack;
    end

    // Descending scan leaves the lowest hit; the "hi" candidate is the lowest at/above ptr.
    always_comb begin
        hi_found = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_lo = PW'(i);
                if (i >= int'(ptr)) begin
                    sel_hi   = PW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        sel_idx = hi_found ? sel_hi : sel_lo;
    end

    // Clear is applied first, then this cycle's lost increment, saturating at 0xFFFF.
    always_comb begin
        lost_sum = {1'b0, (sticky_clear ? 16'h0000 : lost_count)};
        for (int i = 0; i < N; i++) begin
            lost_sum = lost_sum + 17'(lost_bits[i]);
        end
        lost_nxt = lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (|pending) begin
                    state_nxt = PRESENT;
                    load      = 1'b1;
                end
            end
            PRESENT: begin
                if (evt_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            prev       <= '0;
            pending    <= '0;
            sticky     <= '0;
            lost_count <= '0;
            idx        <= '0;
            ptr        <= '0;
        end else begin
            prev       <= flags_in;
            pending    <= (pending & ~ack_mask) | rise;
            sticky     <= (sticky & ~{N{sticky_clear}}) | rise;
            lost_count <= lost_nxt;
            if (load) idx <= sel_idx;
            if (ack)  ptr <= (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_sts_event_arb.sv
// Scoreboarded bench for spi_sts_event_arb with N_GROUPS=16 (128 flags).
module tb_spi_sts_event_arb;
    localparam int N = 128;

    logic          aclk = 1'b0;
    logic          areset, enable, sticky_clear, evt_ready, evt_valid, pending_any;
    logic [N-1:0]  flags_in, sticky;
    logic [15:0]   evt_data, lost_count, held;
    logic [15:0]   exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    spi_sts_event_arb #(.N_GROUPS(16)) dut (
        .aclk(aclk), .areset(areset), .enable(enable), .flags_in(flags_in),
        .sticky_clear(sticky_clear), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_data(evt_data), .sticky(sticky), .lost_count(lost_count),
        .pending_any(pending_any)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !evt_valid && !pending_any) break;
            step();
        end
        chk("drain", N'(exp_q.size() == 0 && !evt_valid && !pending_any), N'(1));
    endtask

    // Handshake completes at the next posedge; compare against the oldest expected word.
    always @(negedge aclk) begin
        if (!areset && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) chk("unexpected_evt", N'(evt_data), {N{1'b1}});
            else                   chk("evt_data", N'(evt_data), N'(exp_q.pop_front()));
        end
    end

    initial begin
        areset = 1'b1; enable = 1'b1; sticky_clear = 1'b0; evt_ready = 1'b0; flags_in = '0;
        step(3);
        areset = 1'b0;
        step();
        chk("rst_valid", N'(evt_valid), '0);
        chk("rst_data", N'(evt_data), '0);
        chk("rst_sticky", sticky, '0);
        chk("rst_lost", N'(lost_count), '0);
        chk("rst_pend", N'(pending_any), '0);

        // Single event on bit 19
        evt_ready = 1'b1;
        flags_in[19] = 1'b1;
        exp_q.push_back(16'h0013);
        step();
        chk("e0_pend", N'(pending_any), N'(1));
        chk("e0_sticky19", N'(sticky[19]), N'(1));
        chk("e0_valid", N'(evt_valid), '0);
        step();
        chk("e1_valid", N'(evt_valid), N'(1));
        chk("e1_data", N'(evt_data), N'(16'h0013));
        step();
        chk("e2_valid", N'(evt_valid), '0);
        chk("e2_pend", N'(pending_any), '0);
        chk("e2_sticky19", N'(sticky[19]), N'(1));
        flags_in = '0;
        step();

        // Bring ptr back to 0 by serving bit 127
        flags_in[127] = 1'b1;
        exp_q.push_back(16'h007F);
        step();
        flags_in = '0;
        drain();

        // Round-robin from ptr=0, then wrap
        flags_in[5] = 1'b1; flags_in[100] = 1'b1; flags_in[127] = 1'b1;
        exp_q.push_back(16'h0005); exp_q.push_back(16'h0064); exp_q.push_back(16'h007F);
        step();
        flags_in = '0;
        drain();
        flags_in[3] = 1'b1; flags_in[127] = 1'b1;
        exp_q.push_back(16'h0003); exp_q.push_back(16'h007F);
        step();
        flags_in = '0;
        drain();

        // Backpressure: three pulses on bit 7 while held
        evt_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            flags_in[7] = 1'b1; step();
            flags_in[7] = 1'b0; step();
        end
        chk("bp_valid", N'(evt_valid), N'(1));
        held = evt_data;
        chk("bp_data", N'(held), N'(16'h0007));
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bp_stable", N'(evt_data), N'(held));
        end
        chk("bp_lost", N'(lost_count), N'(2));
        exp_q.push_back(16'h0007);
        evt_ready = 1'b1;
        drain();
        chk("bp_lost_kept", N'(lost_count), N'(2));

        // Sticky clear coinciding with a rise on bit 40
        flags_in[40] = 1'b1; sticky_clear = 1'b1;
        exp_q.push_back(16'h0028);
        step();
        sticky_clear = 1'b0;
        chk("clr_sticky", sticky, N'(1) << 40);
        chk("clr_lost", N'(lost_count), '0);
        drain();
        flags_in = '0;
        step();
        sticky_clear = 1'b1; step(); sticky_clear = 1'b0;
        chk("clr_all", sticky, '0);

        // Enable gating
        enable = 1'b0;
        flags_in[7:0] = 8'hFF;
        step(4);
        chk("dis_sticky", sticky, '0);
        chk("dis_pend", N'(pending_any), '0);
        chk("dis_valid", N'(evt_valid), '0);
        enable = 1'b1;
        step(4);
        chk("en_sticky", sticky, '0);
        chk("en_pend", N'(pending_any), '0);
        flags_in = '0;
        step();

        // Reset while an event is presented and a lost count is nonzero
        evt_ready = 1'b0;
        flags_in[50] = 1'b1; step();
        flags_in[50] = 1'b0; step();
        flags_in[50] = 1'b1; step();
        chk("mid_valid", N'(evt_valid), N'(1));
        chk("mid_lost", N'(lost_count), N'(1));
        flags_in = '0;
        areset = 1'b1;
        step();
        areset = 1'b0;
        chk("rst2_valid", N'(evt_valid), '0);
        chk("rst2_data", N'(evt_data), '0);
        chk("rst2_pend", N'(pending_any), '0);
        chk("rst2_lost", N'(lost_count), '0);
        step(3);
        chk("rst2_idle", N'(evt_valid), '0);
        chk("sb_empty", N'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
